// File: rtl/uc_eng_queue.sv
`default_nettype none
// ============================================================================
// Module      : uc_eng_queue
// Description : Engine-side unit-clause queue. Buffers derived unit literals,
//               discards duplicates and illegal literals, presents the oldest
//               literal to the arbiter, pops it on grant and flags conflicts
//               against the arbiter broadcast.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_eng_queue #(
   parameter  int UCQ_SIZE  = 16,
   parameter  int UC_LENGTH = 1024,
   localparam int LIT_W     = $clog2(UC_LENGTH),
   localparam int PTR_W     = $clog2(UCQ_SIZE),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    eng_push,
   input  logic signed [LIT_W-1:0] eng_lit,
   input  logic                    uca_grant,
   input  logic                    uca2eng_valid,
   input  logic signed [LIT_W-1:0] uca2eng,
   input  logic                    flush,
   output logic signed [LIT_W-1:0] eng2uca_min,
   output logic                    eng2uca_valid,
   output logic                    eng2uca_empty,
   output logic                    full,
   output logic [CNT_W-1:0]        count,
   output logic                    conflict,
   output logic                    drop
);

   // Most negative literal: its negation is unrepresentable, so it is illegal.
   localparam logic signed [LIT_W-1:0] C_LIT_MIN = {1'b1, {(LIT_W-1){1'b0}}};

   logic signed [LIT_W-1:0] r_mem [UCQ_SIZE];
   logic [PTR_W-1:0]        r_rp;
   logic [PTR_W-1:0]        r_wp;

   logic signed [LIT_W-1:0] w_neg_lit;
   logic signed [LIT_W-1:0] w_neg_bc;
   logic [UCQ_SIZE-1:0]     w_occ;
   logic [UCQ_SIZE-1:0]     w_hit_dup;
   logic [UCQ_SIZE-1:0]     w_hit_neg;
   logic [UCQ_SIZE-1:0]     w_hit_bc;
   logic                    w_legal;
   logic                    w_dup;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_accept;
   logic                    w_dup_rej;
   logic                    w_conf_set;

   assign w_neg_lit = -eng_lit;
   assign w_neg_bc  = -uca2eng;

   // Per-entry occupancy and literal comparators against the pre-edge contents
   // (a head granted this cycle still counts as occupied).
   for (genvar i = 0; i < UCQ_SIZE; i++) begin : g_match
      logic [PTR_W-1:0] w_off;
      assign w_off        = PTR_W'(i) - r_rp;
      assign w_occ[i]     = ({1'b0, w_off} < count);
      assign w_hit_dup[i] = w_occ[i] && (r_mem[i] == eng_lit);
      assign w_hit_neg[i] = w_occ[i] && (r_mem[i] == w_neg_lit);
      assign w_hit_bc[i]  = w_occ[i] && (r_mem[i] == w_neg_bc);
   end

   assign w_legal   = (eng_lit != '0) && (eng_lit != C_LIT_MIN);
   assign w_dup     = |w_hit_dup;
   assign w_pop     = uca_grant && (count != '0);
   assign w_full    = (count == CNT_W'(UCQ_SIZE));
   // When full, a same-cycle grant frees the slot the push needs.
   assign w_accept  = eng_push && w_legal && !w_dup && (!w_full || uca_grant);
   assign w_dup_rej = eng_push && w_legal && w_dup;

   assign w_conf_set = ((w_accept || w_dup_rej) && (|w_hit_neg))
                     || (uca2eng_valid && (|w_hit_bc))
                     || (eng_push && uca2eng_valid && (eng_lit == w_neg_bc));

   // Head presentation comes only from registered state.
   assign eng2uca_min   = (count != '0) ? r_mem[r_rp] : '0;
   assign eng2uca_valid = (count != '0);
   assign eng2uca_empty = (count == '0);
   assign full          = w_full;

   // Pointers, occupancy, drop pulse and sticky conflict; flush wins over all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rp     <= '0;
         r_wp     <= '0;
         count    <= '0;
         conflict <= 1'b0;
         drop     <= 1'b0;
      end else if (flush) begin
         r_rp     <= '0;
         r_wp     <= '0;
         count    <= '0;
         conflict <= 1'b0;
         drop     <= 1'b0;
      end else begin
         if (w_pop)
            r_rp <= r_rp + 1'b1;
         if (w_accept)
            r_wp <= r_wp + 1'b1;
         case ({w_accept, w_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         drop <= eng_push && !w_accept;
         if (w_conf_set)
            conflict <= 1'b1;
      end
   end

   // Literal storage; contents need no reset because occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (w_accept && !flush)
         r_mem[r_wp] <= eng_lit;
   end

endmodule
`default_nettype wire

// File: tb/tb_uc_eng_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_eng_queue
// Description : Self-checking bench for uc_eng_queue: vector table plus
//               hand-written fill/wrap and reset sequences, with a scoreboard
//               queue holding the literals expected at the head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_eng_queue;

   localparam int UCQ_SIZE  = 16;
   localparam int UC_LENGTH = 1024;
   localparam int LIT_W     = 10;
   localparam int CNT_W     = 5;

   logic                    clk;
   logic                    rst_n;
   logic                    eng_push;
   logic signed [LIT_W-1:0] eng_lit;
   logic                    uca_grant;
   logic                    uca2eng_valid;
   logic signed [LIT_W-1:0] uca2eng;
   logic                    flush;
   logic signed [LIT_W-1:0] eng2uca_min;
   logic                    eng2uca_valid;
   logic                    eng2uca_empty;
   logic                    full;
   logic [CNT_W-1:0]        count;
   logic                    conflict;
   logic                    drop;

   int errors = 0;
   int checks = 0;
   int sb[$];

   typedef struct {
      bit p;
      int lit;
      bit g;
      bit bv;
      int bl;
      bit f;
      int ec;
      bit ed;
      bit econf;
   } vec_t;

   vec_t tbl[$];

   uc_eng_queue #(.UCQ_SIZE(UCQ_SIZE), .UC_LENGTH(UC_LENGTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .eng_push      (eng_push),
      .eng_lit       (eng_lit),
      .uca_grant     (uca_grant),
      .uca2eng_valid (uca2eng_valid),
      .uca2eng       (uca2eng),
      .flush         (flush),
      .eng2uca_min   (eng2uca_min),
      .eng2uca_valid (eng2uca_valid),
      .eng2uca_empty (eng2uca_empty),
      .full          (full),
      .count         (count),
      .conflict      (conflict),
      .drop          (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: act=%0d req=%0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit p, input int lit, input bit g, input bit bv,
                               input int bl, input bit f, input int ec, input bit ed,
                               input bit econf);
      vec_t v;
      v.p = p; v.lit = lit; v.g = g; v.bv = bv; v.bl = bl; v.f = f;
      v.ec = ec; v.ed = ed; v.econf = econf;
      return v;
   endfunction

   // One clock cycle: drive, check head against scoreboard on grant, check after edge.
   task automatic cyc(input vec_t v, input string nm);
      int exp_min;
      @(negedge clk);
      eng_push      = v.p;
      eng_lit       = LIT_W'(v.lit);
      uca_grant     = v.g;
      uca2eng_valid = v.bv;
      uca2eng       = LIT_W'(v.bl);
      flush         = v.f;
      if (v.f) begin
         sb.delete();
      end else begin
         if (v.g && sb.size() > 0)
            chk({nm, "_head"}, int'(eng2uca_min), sb.pop_front());
         if (v.p && !v.ed)
            sb.push_back(v.lit);
      end
      @(posedge clk);
      #1;
      exp_min = (sb.size() > 0) ? sb[0] : 0;
      chk({nm, "_count"}, int'(count), v.ec);
      chk({nm, "_drop"}, int'(drop), int'(v.ed));
      chk({nm, "_conflict"}, int'(conflict), int'(v.econf));
      chk({nm, "_min"}, int'(eng2uca_min), exp_min);
      chk({nm, "_valid"}, int'(eng2uca_valid), int'(v.ec != 0));
      chk({nm, "_empty"}, int'(eng2uca_empty), int'(v.ec == 0));
      chk({nm, "_full"}, int'(full), int'(v.ec == UCQ_SIZE));
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_count"}, int'(count), 0);
      chk({nm, "_min"}, int'(eng2uca_min), 0);
      chk({nm, "_valid"}, int'(eng2uca_valid), 0);
      chk({nm, "_empty"}, int'(eng2uca_empty), 1);
      chk({nm, "_full"}, int'(full), 0);
      chk({nm, "_conflict"}, int'(conflict), 0);
      chk({nm, "_drop"}, int'(drop), 0);
   endtask

   initial begin
      //              p  lit   g  bv  bl  f  cnt drop conf
      tbl.push_back(mk(1,   5, 0, 0,  0, 0, 1, 0, 0));
      tbl.push_back(mk(1,  -7, 0, 0,  0, 0, 2, 0, 0));
      tbl.push_back(mk(1,   9, 0, 0,  0, 0, 3, 0, 0));
      tbl.push_back(mk(0,   0, 1, 0,  0, 0, 2, 0, 0));
      tbl.push_back(mk(0,   0, 1, 0,  0, 0, 1, 0, 0));
      tbl.push_back(mk(0,   0, 1, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0,   0, 1, 0,  0, 0, 0, 0, 0));   // grant while empty
      tbl.push_back(mk(1,   3, 0, 0,  0, 0, 1, 0, 0));
      tbl.push_back(mk(1,   3, 0, 0,  0, 0, 1, 1, 0));   // duplicate
      tbl.push_back(mk(1,   0, 0, 0,  0, 0, 1, 1, 0));   // zero literal
      tbl.push_back(mk(1, -512, 0, 0, 0, 0, 1, 1, 0));   // unnegatable literal
      tbl.push_back(mk(0,   0, 1, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1,   4, 0, 0,  0, 0, 1, 0, 0));
      tbl.push_back(mk(0,   0, 0, 1, -4, 0, 1, 0, 1));   // broadcast vs entry
      tbl.push_back(mk(0,   0, 0, 0,  0, 1, 0, 0, 0));   // flush
      tbl.push_back(mk(1,   6, 0, 0,  0, 0, 1, 0, 0));
      tbl.push_back(mk(1,  -6, 0, 0,  0, 0, 2, 0, 1));   // push vs entry, still enqueued
      tbl.push_back(mk(1,  11, 1, 0,  0, 1, 0, 0, 0));   // flush beats push+grant
      tbl.push_back(mk(1,   8, 0, 1, -8, 0, 1, 0, 1));   // push vs broadcast
      tbl.push_back(mk(1,   2, 1, 0,  0, 1, 0, 0, 0));
      tbl.push_back(mk(1,   6, 0, 0,  0, 0, 1, 0, 0));
      tbl.push_back(mk(1,   6, 1, 0,  0, 0, 0, 1, 0));   // dup of head being granted
      tbl.push_back(mk(1,  -5, 0, 1,  5, 0, 1, 0, 1));
      tbl.push_back(mk(0,   0, 0, 0,  0, 1, 0, 0, 0));

      rst_n = 1'b0;
      eng_push = 1'b0; eng_lit = '0; uca_grant = 1'b0;
      uca2eng_valid = 1'b0; uca2eng = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         cyc(tbl[i], $sformatf("v%0d", i));

      // Fill to full, overflow drop, then push-with-grant when full.
      for (int i = 1; i <= UCQ_SIZE; i++)
         cyc(mk(1, i, 0, 0, 0, 0, i, 0, 0), $sformatf("fill%0d", i));
      cyc(mk(1, 17, 0, 0, 0, 0, 16, 1, 0), "ovf_drop");
      cyc(mk(1, 17, 1, 0, 0, 0, 16, 0, 0), "ovf_grant");
      for (int i = UCQ_SIZE - 1; i >= 0; i--)
         cyc(mk(0, 0, 1, 0, 0, 0, i, 0, 0), $sformatf("drain%0d", i));

      // Two more fill/drain rounds so both pointers wrap.
      for (int r = 0; r < 2; r++) begin
         for (int i = 1; i <= UCQ_SIZE; i++)
            cyc(mk(1, 100 * (r + 2) + i, 0, 0, 0, 0, i, 0, 0), $sformatf("r%0d_fill%0d", r, i));
         for (int i = UCQ_SIZE - 1; i >= 0; i--)
            cyc(mk(0, 0, 1, 0, 0, 0, i, 0, 0), $sformatf("r%0d_drain%0d", r, i));
      end

      // Mid-stream asynchronous reset with seven entries held.
      for (int i = 1; i <= 7; i++)
         cyc(mk(1, 20 + i, 0, 0, 0, 0, i, 0, 0), $sformatf("pre%0d", i));
      @(negedge clk);
      eng_push = 1'b0; uca_grant = 1'b0; uca2eng_valid = 1'b0; flush = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(mk(1, 1, 0, 0, 0, 0, 1, 0, 0), "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uc_eng_queue.md
# uc_eng_queue

Engine-side unit-clause queue: the transmitting end of the engine-to-arbiter link of the unit-clause arbiter. Each BCP engine owns one instance. It buffers unit literals the engine derives, drops duplicates, and presents the oldest literal to the arbiter as `eng2uca_min` / `eng2uca_valid` / `eng2uca_empty`. It pops that literal on arbiter grant, and watches the arbiter broadcast (`uca2eng`) to flag a local conflict.

## Interface
Parameters:
- `UCQ_SIZE`, 16: queue depth (power of two, ≥2).
- `UC_LENGTH`, 1024: literal space; `LIT_W = $clog2(UC_LENGTH)`; literals are signed `LIT_W` bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `eng_push`  in  1  engine offers a derived literal this cycle.
- `eng_lit`  in  LIT_W signed  literal offered with `eng_push`.
- `uca_grant`  in  1  arbiter consumes the current head this cycle.
- `uca2eng_valid`  in  1  arbiter broadcast valid.
- `uca2eng`  in  LIT_W signed  broadcast literal.
- `flush`  in  1  synchronous clear of queue and conflict flag.
- `eng2uca_min`  out  LIT_W signed  head literal; 0 when empty.
- `eng2uca_valid`  out  1  head is valid (= !empty).
- `eng2uca_empty`  out  1  queue empty.
- `full`  out  1  count == UCQ_SIZE.
- `count`  out  $clog2(UCQ_SIZE)+1  occupied entries.
- `conflict`  out  1  sticky contradiction flag.
- `drop`  out  1  one-cycle pulse: a push was discarded because of full, illegal, or duplicate.

## Operation
- Storage: circular buffer of `UCQ_SIZE` entries, read pointer `rp`, write pointer `wp`, and `count`. Pointers wrap modulo `UCQ_SIZE`.
- Legal literal: nonzero and not equal to -2^(LIT_W-1), because its negation is unrepresentable. An illegal push is discarded and pulses `drop`.
- Duplicate check: a push whose `eng_lit` equals any occupied entry is discarded with `drop`. This includes the head being granted in the same cycle. A duplicate that also hits `conflict` still sets `conflict`.
- Push acceptance: a legal, non-duplicate push is accepted if `count < UCQ_SIZE`, or if `full && uca_grant` (pop and push in the same cycle). Otherwise it is discarded with `drop`.
- Pop: `uca_grant` with `count > 0` advances `rp`. A grant while empty is ignored.
- `count` update: +1 on push only, −1 on pop only, unchanged on push+pop.
- `conflict` is set at the edge when any of these holds:
  - an accepted or duplicate-rejected push has `eng_lit == -E` for some occupied entry E;
  - `uca2eng_valid` and `uca2eng == -E` for some occupied E;
  - `eng_push && uca2eng_valid && eng_lit == -uca2eng`.
  - A push that sets `conflict` is still enqueued if otherwise acceptable.
- Occupancy for the conflict compare is the pre-edge contents, including a head granted in that cycle.
- `conflict` stays set until `flush` or reset.
- `flush` clears `rp`, `wp`, `count` and `conflict`. It has priority over push, grant and conflict set in the same cycle. `drop` is 0 during flush.
- `eng2uca_min` = storage[`rp`] when non-empty, else 0. It is driven from registered state only; there is no combinational path from any input to any output.

## Timing
- Reset (async assert, sync-safe release): `count`=0, `rp`=`wp`=0, `eng2uca_min`=0, `eng2uca_valid`=0, `eng2uca_empty`=1, `full`=0, `conflict`=0, `drop`=0.
- Push-to-head latency: 1 cycle. A literal pushed into an empty queue at edge N appears on `eng2uca_min` with `eng2uca_valid`=1 after edge N.
- Grant-to-next-head: 1 cycle. The next literal, or empty, is visible after the granting edge.
- `drop` and `conflict` update at the same edge as the offending push or broadcast.
- Reset asserted mid-operation discards all contents immediately. There is no partial state on release.

## Test plan
- Reset, then push 5, −7, 9 on consecutive cycles → after 3rd edge `count`=3, `eng2uca_min`=5, `eng2uca_valid`=1, `eng2uca_empty`=0. Three grants yield 5, −7, 9, then `eng2uca_empty`=1 and `eng2uca_min`=0.
- Fill 16 distinct literals 1..16 → `full`=1. Push 17 alone → `drop` pulse, `count`=16. Push 17 together with grant → accepted, head becomes 2, `count`=16. Fill/drain twice more to exercise `rp`/`wp` wrap with FIFO order preserved.
- Push 3, then push 3 again → `drop`=1, `count`=1. Push 0 and push −512 (LIT_W=10) → `drop` each, `count` unchanged.
- Queue holds 4. Broadcast `uca2eng`=−4 → `conflict`=1 next edge, queue unchanged. Separately, queue holds 6 and push −6 → `conflict`=1 and `count`=2.
- Same cycle: push 8 with broadcast −8 → `conflict`=1. Later `flush` while push and grant are active → `count`=0, `conflict`=0, `drop`=0.
- Assert `rst_n`=0 mid-stream with `count`=7 → all outputs at reset values before the next clock edge. Release, push 1 → head 1 after one edge.
